// File: rtl/cachemem_pkg.sv
// cachemem_pkg
//   Shared defaults and helpers for the set-associative cache memory.
//   - DEF_DATA_W / DEF_TAG_W / DEF_IDX_W : default geometry (64-bit lines,
//     22-bit tags, 128 sets).
//   - MAX_WAY_W : widest way index the result struct can carry (WAYS <= 4).
//   - clog2_min1 : ceil(log2(n)), never less than 1; sizes the age and
//     way-index fields.
//   - way_sel_t : outcome of a write-side set lookup.
package cachemem_pkg;

   localparam int DEF_DATA_W = 64;
   localparam int DEF_TAG_W  = 22;
   localparam int DEF_IDX_W  = 7;
   localparam int MAX_WAY_W  = 2;

   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         r = ((32'd1 << i) < n) ? (i + 1) : r;
      end
      return (r < 1) ? 1 : r;
   endfunction

   // Write-side lookup result: hit flag and hitting way, plus the way that
   // would be replaced on a miss and whether that line holds dirty data.
   typedef struct packed {
      logic                 hit;
      logic [MAX_WAY_W-1:0] way;
      logic [MAX_WAY_W-1:0] victim_way;
      logic                 victim_dirty;
   } way_sel_t;

endpackage

// File: rtl/cachemem_assoc_lru.sv
// cache_lru_update
//   Combinational true-LRU age update for one set.
//   Ports:
//     age_in    : current age of every way (0 = MRU, WAYS-1 = LRU)
//     touch_en  : apply the touch; when low age_out equals age_in
//     touch_way : way being touched
//     age_out   : ages after the touch (touched way 0, younger ways +1)
module cache_lru_update
   import cachemem_pkg::*;
#(
   parameter int WAYS  = 2,
   parameter int AGE_W = 1
) (
   input  logic [WAYS-1:0][AGE_W-1:0] age_in,
   input  logic                       touch_en,
   input  logic [AGE_W-1:0]           touch_way,
   output logic [WAYS-1:0][AGE_W-1:0] age_out
);

   logic [AGE_W-1:0] old_age_s;

   // Age currently held by the touched way.
   always_comb begin
      old_age_s = {AGE_W{1'b0}};
      for (int w = 0; w < WAYS; w++) begin
         old_age_s = (touch_way == AGE_W'(w)) ? age_in[w] : old_age_s;
      end
   end

   // Touched way becomes MRU; every way younger than it ages by one.
   always_comb begin
      age_out = age_in;
      for (int w = 0; w < WAYS; w++) begin
         if (!touch_en) begin
            age_out[w] = age_in[w];
         end else if (touch_way == AGE_W'(w)) begin
            age_out[w] = {AGE_W{1'b0}};
         end else if (age_in[w] < old_age_s) begin
            age_out[w] = age_in[w] + AGE_W'(1'b1);
         end else begin
            age_out[w] = age_in[w];
         end
      end
   end

endmodule

// File: rtl/cachemem_assoc.sv
// cachemem_assoc
//   SETS x WAYS cache memory: data, tag, valid, dirty and true-LRU ages.
//   Ports:
//     clock, reset            : rising-edge clock, synchronous active-high reset
//     rd1_*                   : combinational lookup; rd1_en marks a real access
//                               that refreshes LRU on a hit
//     wr1_*                   : write/fill; hit updates in place, miss replaces
//                               the lowest invalid way or else the LRU way
//     inv_*                   : invalidate a matching valid line (no writeback)
//     evict_*                 : registered one-cycle pulse carrying a displaced
//                               dirty line, one cycle after the write
module cachemem_assoc
   import cachemem_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int TAG_W  = DEF_TAG_W,
   parameter int IDX_W  = DEF_IDX_W,
   parameter int WAYS   = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              rd1_en,
   input  logic [IDX_W-1:0]  rd1_idx,
   input  logic [TAG_W-1:0]  rd1_tag,
   output logic [DATA_W-1:0] rd1_data,
   output logic              rd1_valid,
   input  logic              wr1_en,
   input  logic [IDX_W-1:0]  wr1_idx,
   input  logic [TAG_W-1:0]  wr1_tag,
   input  logic [DATA_W-1:0] wr1_data,
   input  logic              wr1_dirty,
   input  logic              inv_en,
   input  logic [IDX_W-1:0]  inv_idx,
   input  logic [TAG_W-1:0]  inv_tag,
   output logic              evict_valid,
   output logic [IDX_W-1:0]  evict_idx,
   output logic [TAG_W-1:0]  evict_tag,
   output logic [DATA_W-1:0] evict_data
);

   localparam int SETS  = 1 << IDX_W;
   localparam int AGE_W = clog2_min1(WAYS);
   localparam int WAY_W = AGE_W;

   typedef logic [WAYS-1:0][AGE_W-1:0] age_vec_t;

   logic [DATA_W-1:0] data_mem [SETS][WAYS];
   logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
   logic [WAYS-1:0]   valid_r  [SETS];
   logic [WAYS-1:0]   dirty_r  [SETS];
   age_vec_t          age_r    [SETS];

   logic              evict_valid_r;
   logic [IDX_W-1:0]  evict_idx_r;
   logic [TAG_W-1:0]  evict_tag_r;
   logic [DATA_W-1:0] evict_data_r;

   logic              rd_hit_s;
   logic [WAY_W-1:0]  rd_way_s;
   logic              wr_hit_s;
   logic [WAY_W-1:0]  wr_hit_way_s;
   logic [WAY_W-1:0]  vict_age_way_s;
   logic [WAY_W-1:0]  vict_free_way_s;
   logic [WAY_W-1:0]  vict_way_s;
   logic              any_free_s;
   way_sel_t          wr_sel_s;
   logic [WAY_W-1:0]  wr_way_s;
   logic              inv_hit_s;
   logic [WAY_W-1:0]  inv_way_s;
   logic              same_way_kill_s;
   logic              new_dirty_s;
   logic              evict_now_s;
   logic              rd_touch_s;
   age_vec_t          age_rd_s;
   age_vec_t          age_wr_in_s;
   age_vec_t          age_wr_s;

   // Read lookup; scanning downward lets the lowest matching way win.
   always_comb begin
      rd_hit_s = 1'b0;
      rd_way_s = {WAY_W{1'b0}};
      for (int w = WAYS - 1; w >= 0; w--) begin
         rd_way_s = (valid_r[rd1_idx][w] && (tag_mem[rd1_idx][w] == rd1_tag)) ? WAY_W'(w) : rd_way_s;
         rd_hit_s = rd_hit_s | (valid_r[rd1_idx][w] && (tag_mem[rd1_idx][w] == rd1_tag));
      end
   end

   assign rd1_valid = rd_hit_s;
   assign rd1_data  = rd_hit_s ? data_mem[rd1_idx][rd_way_s] : {DATA_W{1'b0}};

   // Write-side lookup and victim choice, both from start-of-cycle state.
   always_comb begin
      wr_hit_s        = 1'b0;
      wr_hit_way_s    = {WAY_W{1'b0}};
      vict_age_way_s  = {WAY_W{1'b0}};
      vict_free_way_s = {WAY_W{1'b0}};
      any_free_s      = 1'b0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         wr_hit_way_s    = (valid_r[wr1_idx][w] && (tag_mem[wr1_idx][w] == wr1_tag)) ? WAY_W'(w) : wr_hit_way_s;
         wr_hit_s        = wr_hit_s | (valid_r[wr1_idx][w] && (tag_mem[wr1_idx][w] == wr1_tag));
         vict_age_way_s  = (age_r[wr1_idx][w] == AGE_W'(WAYS - 1)) ? WAY_W'(w) : vict_age_way_s;
         vict_free_way_s = (!valid_r[wr1_idx][w]) ? WAY_W'(w) : vict_free_way_s;
         any_free_s      = any_free_s | !valid_r[wr1_idx][w];
      end
      vict_way_s            = any_free_s ? vict_free_way_s : vict_age_way_s;
      wr_sel_s.hit          = wr_hit_s;
      wr_sel_s.way          = MAX_WAY_W'(wr_hit_way_s);
      wr_sel_s.victim_way   = MAX_WAY_W'(vict_way_s);
      wr_sel_s.victim_dirty = valid_r[wr1_idx][vict_way_s] & dirty_r[wr1_idx][vict_way_s];
   end

   // Invalidate lookup in its own set.
   always_comb begin
      inv_hit_s = 1'b0;
      inv_way_s = {WAY_W{1'b0}};
      for (int w = WAYS - 1; w >= 0; w--) begin
         inv_way_s = (valid_r[inv_idx][w] && (tag_mem[inv_idx][w] == inv_tag)) ? WAY_W'(w) : inv_way_s;
         inv_hit_s = inv_hit_s | (valid_r[inv_idx][w] && (tag_mem[inv_idx][w] == inv_tag));
      end
   end

   assign wr_way_s = wr_sel_s.hit ? WAY_W'(wr_sel_s.way) : WAY_W'(wr_sel_s.victim_way);

   // An invalidate of the very line being written is applied first: its old
   // dirty state is discarded and it is never written back.
   assign same_way_kill_s = inv_en && inv_hit_s && (inv_idx == wr1_idx) && (inv_way_s == wr_way_s);
   assign new_dirty_s     = wr_sel_s.hit ? ((dirty_r[wr1_idx][wr_way_s] & ~same_way_kill_s) | wr1_dirty) : wr1_dirty;
   assign evict_now_s     = wr1_en && !wr_sel_s.hit && wr_sel_s.victim_dirty && !same_way_kill_s;

   // Read touch feeds the write touch when both hit the same set, so the
   // written way ends MRU.
   assign rd_touch_s  = rd1_en && rd_hit_s;
   assign age_wr_in_s = (rd1_idx == wr1_idx) ? age_rd_s : age_r[wr1_idx];

   cache_lru_update #(.WAYS(WAYS), .AGE_W(AGE_W)) u_lru_rd (
      .age_in    (age_r[rd1_idx]),
      .touch_en  (rd_touch_s),
      .touch_way (rd_way_s),
      .age_out   (age_rd_s)
   );

   cache_lru_update #(.WAYS(WAYS), .AGE_W(AGE_W)) u_lru_wr (
      .age_in    (age_wr_in_s),
      .touch_en  (wr1_en),
      .touch_way (wr_way_s),
      .age_out   (age_wr_s)
   );

   // Line state, LRU ages and eviction register; later assignments win.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int s = 0; s < SETS; s++) begin
            valid_r[s] <= {WAYS{1'b0}};
            dirty_r[s] <= {WAYS{1'b0}};
            for (int w = 0; w < WAYS; w++) begin
               age_r[s][w] <= AGE_W'(w);
            end
         end
         evict_valid_r <= 1'b0;
         evict_idx_r   <= {IDX_W{1'b0}};
         evict_tag_r   <= {TAG_W{1'b0}};
         evict_data_r  <= {DATA_W{1'b0}};
      end else begin
         if (rd_touch_s) begin
            age_r[rd1_idx] <= age_rd_s;
         end
         if (inv_en && inv_hit_s) begin
            valid_r[inv_idx][inv_way_s] <= 1'b0;
            dirty_r[inv_idx][inv_way_s] <= 1'b0;
         end
         if (wr1_en) begin
            age_r[wr1_idx]              <= age_wr_s;
            valid_r[wr1_idx][wr_way_s]  <= 1'b1;
            dirty_r[wr1_idx][wr_way_s]  <= new_dirty_s;
         end
         evict_valid_r <= evict_now_s;
         if (evict_now_s) begin
            evict_idx_r  <= wr1_idx;
            evict_tag_r  <= tag_mem[wr1_idx][wr_way_s];
            evict_data_r <= data_mem[wr1_idx][wr_way_s];
         end
      end
   end

   // Data and tag arrays carry no reset.
   always_ff @(posedge clock) begin
      if (!reset && wr1_en) begin
         data_mem[wr1_idx][wr_way_s] <= wr1_data;
         tag_mem[wr1_idx][wr_way_s]  <= wr1_tag;
      end
   end

   assign evict_valid = evict_valid_r;
   assign evict_idx   = evict_idx_r;
   assign evict_tag   = evict_tag_r;
   assign evict_data  = evict_data_r;

endmodule

// File: tb/tb_cachemem_assoc.sv
// tb_cachemem_assoc
//   Drives a 2-way and a 4-way instance with identical stimulus and checks
//   both against a recency-list model of the cache every cycle, plus
//   hand-computed expectations for the directed scenarios.
module tb_cachemem_assoc;

   logic        clock = 1'b0;
   logic        reset;
   logic        rd1_en;
   logic [6:0]  rd1_idx;
   logic [21:0] rd1_tag;
   logic        wr1_en;
   logic [6:0]  wr1_idx;
   logic [21:0] wr1_tag;
   logic [63:0] wr1_data;
   logic        wr1_dirty;
   logic        inv_en;
   logic [6:0]  inv_idx;
   logic [21:0] inv_tag;

   logic [63:0] rd_data_k  [2];
   logic        rd_valid_k [2];
   logic        ev_valid_k [2];
   logic [6:0]  ev_idx_k   [2];
   logic [21:0] ev_tag_k   [2];
   logic [63:0] ev_data_k  [2];

   // staged inputs for the next cycle
   logic        n_reset, n_rd_en, n_wr_en, n_wr_dirty, n_inv_en;
   logic [6:0]  n_rd_idx, n_wr_idx, n_inv_idx;
   logic [21:0] n_rd_tag, n_wr_tag, n_inv_tag;
   logic [63:0] n_wr_data;

   // model: per instance/set/way line contents, plus recency list (pos 0 = MRU)
   logic        m_valid [2][128][4];
   logic        m_dirty [2][128][4];
   logic [21:0] m_tag   [2][128][4];
   logic [63:0] m_data  [2][128][4];
   int          m_ord   [2][128][4];
   logic        exp_ev_valid [2];
   logic [6:0]  exp_ev_idx   [2];
   logic [21:0] exp_ev_tag   [2];
   logic [63:0] exp_ev_data  [2];

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   cachemem_assoc #(.WAYS(2)) dut2 (
      .clock(clock), .reset(reset),
      .rd1_en(rd1_en), .rd1_idx(rd1_idx), .rd1_tag(rd1_tag),
      .rd1_data(rd_data_k[0]), .rd1_valid(rd_valid_k[0]),
      .wr1_en(wr1_en), .wr1_idx(wr1_idx), .wr1_tag(wr1_tag),
      .wr1_data(wr1_data), .wr1_dirty(wr1_dirty),
      .inv_en(inv_en), .inv_idx(inv_idx), .inv_tag(inv_tag),
      .evict_valid(ev_valid_k[0]), .evict_idx(ev_idx_k[0]),
      .evict_tag(ev_tag_k[0]), .evict_data(ev_data_k[0])
   );

   cachemem_assoc #(.WAYS(4)) dut4 (
      .clock(clock), .reset(reset),
      .rd1_en(rd1_en), .rd1_idx(rd1_idx), .rd1_tag(rd1_tag),
      .rd1_data(rd_data_k[1]), .rd1_valid(rd_valid_k[1]),
      .wr1_en(wr1_en), .wr1_idx(wr1_idx), .wr1_tag(wr1_tag),
      .wr1_data(wr1_data), .wr1_dirty(wr1_dirty),
      .inv_en(inv_en), .inv_idx(inv_idx), .inv_tag(inv_tag),
      .evict_valid(ev_valid_k[1]), .evict_idx(ev_idx_k[1]),
      .evict_tag(ev_tag_k[1]), .evict_data(ev_data_k[1])
   );

   function automatic int nw(input int k);
      return (k == 0) ? 2 : 4;
   endfunction

   task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s ways=%0d actual=%h required=%h", name, nw(k), act, exp);
      end
   endtask

   function automatic int m_lookup(input int k, input int s, input logic [21:0] t);
      for (int w = 0; w < nw(k); w++) begin
         if (m_valid[k][s][w] && (m_tag[k][s][w] == t)) return w;
      end
      return -1;
   endfunction

   task automatic m_reset(input int k);
      for (int s = 0; s < 128; s++) begin
         for (int w = 0; w < 4; w++) begin
            m_valid[k][s][w] = 1'b0;
            m_dirty[k][s][w] = 1'b0;
            m_tag[k][s][w]   = 22'd0;
            m_data[k][s][w]  = 64'd0;
            m_ord[k][s][w]   = w;
         end
      end
   endtask

   // move way w to the front of its set's recency list
   task automatic m_touch(input int k, input int s, input int w);
      int p;
      p = 0;
      for (int i = 0; i < nw(k); i++) begin
         if (m_ord[k][s][i] == w) p = i;
      end
      for (int i = p; i > 0; i--) m_ord[k][s][i] = m_ord[k][s][i-1];
      m_ord[k][s][0] = w;
   endtask

   // advance the model by one clock edge using the inputs now applied
   task automatic m_step(input int k);
      int rh, wh, ih, vict, tw, n;
      logic ov, od;
      logic [21:0] otag;
      logic [63:0] odata;
      n  = nw(k);
      tw = 0;
      exp_ev_valid[k] = 1'b0;
      if (reset) begin
         m_reset(k);
         return;
      end
      rh = m_lookup(k, rd1_idx, rd1_tag);
      wh = m_lookup(k, wr1_idx, wr1_tag);
      ih = inv_en ? m_lookup(k, inv_idx, inv_tag) : -1;
      vict = m_ord[k][wr1_idx][n-1];
      for (int w = n - 1; w >= 0; w--) begin
         if (!m_valid[k][wr1_idx][w]) vict = w;
      end
      ov    = m_valid[k][wr1_idx][vict];
      od    = m_dirty[k][wr1_idx][vict];
      otag  = m_tag[k][wr1_idx][vict];
      odata = m_data[k][wr1_idx][vict];
      if (ih >= 0) begin
         m_valid[k][inv_idx][ih] = 1'b0;
         m_dirty[k][inv_idx][ih] = 1'b0;
      end
      if (wr1_en) begin
         tw = (wh >= 0) ? wh : vict;
         if (wh < 0 && ov && od && !(ih >= 0 && inv_idx == wr1_idx && ih == vict)) begin
            exp_ev_valid[k] = 1'b1;
            exp_ev_idx[k]   = wr1_idx;
            exp_ev_tag[k]   = otag;
            exp_ev_data[k]  = odata;
         end
         m_dirty[k][wr1_idx][tw] = (wh >= 0) ? (m_dirty[k][wr1_idx][tw] | wr1_dirty) : wr1_dirty;
         m_valid[k][wr1_idx][tw] = 1'b1;
         m_tag[k][wr1_idx][tw]   = wr1_tag;
         m_data[k][wr1_idx][tw]  = wr1_data;
      end
      if (rd1_en && rh >= 0) m_touch(k, rd1_idx, rh);
      if (wr1_en) m_touch(k, wr1_idx, tw);
   endtask

   task automatic clr();
      n_reset = 1'b0; n_rd_en = 1'b0; n_wr_en = 1'b0; n_wr_dirty = 1'b0; n_inv_en = 1'b0;
      n_rd_idx = 7'd0; n_wr_idx = 7'd0; n_inv_idx = 7'd0;
      n_rd_tag = 22'd0; n_wr_tag = 22'd0; n_inv_tag = 22'd0; n_wr_data = 64'd0;
   endtask

   task automatic rd(input logic [6:0] i, input logic [21:0] t, input logic en);
      n_rd_en = en; n_rd_idx = i; n_rd_tag = t;
   endtask

   task automatic wr(input logic [6:0] i, input logic [21:0] t, input logic [63:0] d, input logic dirty);
      n_wr_en = 1'b1; n_wr_idx = i; n_wr_tag = t; n_wr_data = d; n_wr_dirty = dirty;
   endtask

   // One cycle: check last edge's eviction, apply inputs, check lookup,
   // then step the model across the coming edge.
   task automatic cycle();
      int e;
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
         chk("evict_valid", k, 64'(ev_valid_k[k]), 64'(exp_ev_valid[k]));
         if (exp_ev_valid[k]) begin
            chk("evict_idx", k, 64'(ev_idx_k[k]), 64'(exp_ev_idx[k]));
            chk("evict_tag", k, 64'(ev_tag_k[k]), 64'(exp_ev_tag[k]));
            chk("evict_data", k, ev_data_k[k], exp_ev_data[k]);
         end
      end
      reset = n_reset; rd1_en = n_rd_en; rd1_idx = n_rd_idx; rd1_tag = n_rd_tag;
      wr1_en = n_wr_en; wr1_idx = n_wr_idx; wr1_tag = n_wr_tag; wr1_data = n_wr_data;
      wr1_dirty = n_wr_dirty; inv_en = n_inv_en; inv_idx = n_inv_idx; inv_tag = n_inv_tag;
      #1;
      for (int k = 0; k < 2; k++) begin
         e = m_lookup(k, rd1_idx, rd1_tag);
         chk("rd1_valid", k, 64'(rd_valid_k[k]), 64'(e >= 0));
         chk("rd1_data", k, rd_data_k[k], (e >= 0) ? m_data[k][rd1_idx][e] : 64'd0);
      end
      for (int k = 0; k < 2; k++) m_step(k);
   endtask

   initial begin
      reset = 1'b1; rd1_en = 1'b0; rd1_idx = 7'd0; rd1_tag = 22'd0;
      wr1_en = 1'b0; wr1_idx = 7'd0; wr1_tag = 22'd0; wr1_data = 64'd0; wr1_dirty = 1'b0;
      inv_en = 1'b0; inv_idx = 7'd0; inv_tag = 22'd0;
      for (int k = 0; k < 2; k++) begin
         m_reset(k);
         exp_ev_valid[k] = 1'b0;
      end
      clr(); n_reset = 1'b1; cycle(); cycle();

      // reset state
      clr(); rd(7'd5, 22'h3, 1'b1); cycle();
      chk("tp_reset_rd_valid", 0, 64'(rd_valid_k[0]), 64'd0);
      chk("tp_reset_rd_data", 0, rd_data_k[0], 64'd0);
      chk("tp_reset_evict", 0, 64'(ev_valid_k[0]), 64'd0);

      // 2-way scenario in set 5
      clr(); wr(7'd5, 22'hA, 64'h11, 1'b1); cycle();
      clr(); wr(7'd5, 22'hB, 64'h22, 1'b0); cycle();
      clr(); rd(7'd5, 22'hA, 1'b1); cycle();
      chk("tp_rd_A", 0, rd_data_k[0], 64'h11);
      clr(); wr(7'd5, 22'hC, 64'h33, 1'b0); cycle();
      clr(); rd(7'd5, 22'hB, 1'b0); cycle();
      chk("tp_B_replaced", 0, 64'(rd_valid_k[0]), 64'd0);
      chk("tp_clean_no_evict", 0, 64'(ev_valid_k[0]), 64'd0);
      clr(); rd(7'd5, 22'hC, 1'b0); cycle();
      chk("tp_rd_C", 0, rd_data_k[0], 64'h33);
      clr(); wr(7'd5, 22'hD, 64'h55, 1'b1); cycle();
      clr(); cycle();
      chk("tp_evA_valid", 0, 64'(ev_valid_k[0]), 64'd1);
      chk("tp_evA_idx", 0, 64'(ev_idx_k[0]), 64'd5);
      chk("tp_evA_tag", 0, 64'(ev_tag_k[0]), 64'hA);
      chk("tp_evA_data", 0, ev_data_k[0], 64'h11);
      clr(); wr(7'd5, 22'hC, 64'h44, 1'b1); cycle();
      chk("tp_evA_pulse_end", 0, 64'(ev_valid_k[0]), 64'd0);
      clr(); rd(7'd5, 22'hD, 1'b1); cycle();
      chk("tp_hit_no_evict", 0, 64'(ev_valid_k[0]), 64'd0);
      chk("tp_rd_D", 0, rd_data_k[0], 64'h55);
      clr(); wr(7'd5, 22'hF, 64'h66, 1'b0); cycle();
      clr(); cycle();
      chk("tp_evC_valid", 0, 64'(ev_valid_k[0]), 64'd1);
      chk("tp_evC_tag", 0, 64'(ev_tag_k[0]), 64'hC);
      chk("tp_evC_data", 0, ev_data_k[0], 64'h44);
      clr(); wr(7'd5, 22'hE, 64'h77, 1'b0); n_inv_en = 1'b1; n_inv_idx = 7'd5; n_inv_tag = 22'hD; cycle();
      clr(); rd(7'd5, 22'hE, 1'b1); cycle();
      chk("tp_inv_no_evict", 0, 64'(ev_valid_k[0]), 64'd0);
      chk("tp_rd_E", 0, rd_data_k[0], 64'h77);
      clr(); rd(7'd5, 22'hD, 1'b1); cycle();
      chk("tp_D_gone", 0, 64'(rd_valid_k[0]), 64'd0);

      // 4-way scenario in set 9
      for (int i = 0; i < 4; i++) begin
         clr(); wr(7'd9, 22'h100 + 22'(i), 64'h1000 + 64'(i), 1'b1); cycle();
      end
      clr(); rd(7'd9, 22'h102, 1'b1); cycle();
      clr(); rd(7'd9, 22'h100, 1'b1); cycle();
      clr(); rd(7'd9, 22'h103, 1'b1); cycle();
      clr(); rd(7'd9, 22'h101, 1'b1); cycle();
      clr(); wr(7'd9, 22'h104, 64'h1004, 1'b0); cycle();
      clr(); rd(7'd9, 22'h102, 1'b0); cycle();
      chk("tp4_ev_valid", 1, 64'(ev_valid_k[1]), 64'd1);
      chk("tp4_ev_tag", 1, 64'(ev_tag_k[1]), 64'h102);
      chk("tp4_ev_data", 1, ev_data_k[1], 64'h1002);
      chk("tp4_way2_gone", 1, 64'(rd_valid_k[1]), 64'd0);
      clr(); rd(7'd9, 22'h100, 1'b0); cycle();
      chk("tp4_rd_100", 1, rd_data_k[1], 64'h1000);
      // reset in the same cycle as a dirty-victim write
      clr(); n_reset = 1'b1; wr(7'd9, 22'h105, 64'h1005, 1'b1); cycle();
      clr(); rd(7'd9, 22'h101, 1'b1); cycle();
      chk("tp4_rst_evict", 1, 64'(ev_valid_k[1]), 64'd0);
      chk("tp4_rst_miss", 1, 64'(rd_valid_k[1]), 64'd0);
      chk("tp4_rst_miss2", 0, 64'(rd_valid_k[0]), 64'd0);

      // random traffic on a few sets and tags
      for (int c = 0; c < 4000; c++) begin
         clr();
         n_reset    = ($urandom_range(299) == 0);
         n_rd_en    = 1'($urandom_range(1));
         n_rd_idx   = 7'($urandom_range(3));
         n_rd_tag   = 22'($urandom_range(6));
         n_wr_en    = ($urandom_range(9) < 6);
         n_wr_idx   = 7'($urandom_range(3));
         n_wr_tag   = 22'($urandom_range(6));
         n_wr_data  = {$urandom, $urandom};
         n_wr_dirty = 1'($urandom_range(1));
         n_inv_en   = ($urandom_range(4) == 0);
         n_inv_idx  = ($urandom_range(1) == 0) ? n_wr_idx : 7'($urandom_range(3));
         n_inv_tag  = 22'($urandom_range(6));
         cycle();
      end
      clr(); cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cachemem_assoc.md
Name: cachemem_assoc

Overview:
- Parametrised set-associative successor to the team's direct-mapped 128x64 cache memory.
- Stores SETS x WAYS lines of data, tag, valid and dirty bits.
- Provides a combinational hit lookup, true-LRU replacement, per-line invalidate, and a registered dirty-victim eviction port for writeback.
- Sits between the core-side cache controller and memory-side writeback logic.

Parameters:
- DATA_W, 64, line data width in bits.
- TAG_W, 22, tag width in bits.
- IDX_W, 7, set index width; SETS = 2**IDX_W.
- WAYS, 2, associativity. Legal values: 1, 2, 4. AGE_W = max(1, log2(WAYS)).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- rd1_en  in  1  lookup is a real access; update LRU on hit.
- rd1_idx  in  IDX_W  lookup set.
- rd1_tag  in  TAG_W  lookup tag.
- rd1_data  out  DATA_W  data of the hitting way; 0 on miss.
- rd1_valid  out  1  hit (valid way with matching tag).
- wr1_en  in  1  write/fill request.
- wr1_idx  in  IDX_W  write set.
- wr1_tag  in  TAG_W  write tag.
- wr1_data  in  DATA_W  write data.
- wr1_dirty  in  1  1 = store (mark dirty); 0 = clean fill.
- inv_en  in  1  invalidate request.
- inv_idx  in  IDX_W  invalidate set.
- inv_tag  in  TAG_W  invalidate tag.
- evict_valid  out  1  one-cycle pulse: dirty victim displaced.
- evict_idx  out  IDX_W  victim set.
- evict_tag  out  TAG_W  victim tag.
- evict_data  out  DATA_W  victim data.

Behaviour:
- Reset:
  - All valid and dirty bits = 0.
  - Way w age = w in every set (way 0 MRU, way WAYS-1 LRU).
  - evict_valid, evict_idx, evict_tag and evict_data = 0.
  - Data and tag arrays are not reset.
  - Any write, invalidate or pending evict in the reset cycle is dropped.
- Read:
  - Purely combinational; sees state as of the start of the cycle. No same-cycle write forwarding.
  - Multiple matching ways cannot occur by construction. If they do, the lowest way wins.
- LRU:
  - Per set, each way holds an age 0..WAYS-1; ages form a permutation.
  - Touching way w sets its age to 0 and increments every way with age < old age(w).
  - Touch events: read hit with rd1_en, and any write.
  - If a read and a write touch the same set in one cycle, apply the read touch first, then the write touch, so the written way ends MRU.
- Write hit (valid way with tag == wr1_tag):
  - Update data in place.
  - dirty |= wr1_dirty.
  - No eviction.
- Write miss, victim selection:
  - Lowest-index invalid way if any, else the way with age WAYS-1.
  - Victim receives tag and data; valid = 1; dirty = wr1_dirty.
- Eviction:
  - If the victim was valid and dirty, next cycle evict_valid = 1 with the victim's old idx, tag and data (registered, latency 1).
  - Otherwise evict_valid = 0 next cycle.
  - Downstream must accept every pulse; there is no backpressure.
- Invalidate:
  - A matching valid way gets valid = 0 and dirty = 0. No eviction (the caller flushes first if needed). LRU unchanged.
  - A miss is a no-op.
- Invalidate and write in the same cycle, same set:
  - Victim/hit selection uses pre-invalidate state.
  - If both target the same way, the write wins (line valid with new contents).
- WAYS = 1 degenerates to direct-mapped with evict support. The age logic is constant.
- Writes to different sets in consecutive cycles are fully pipelined; one write per cycle sustained.

Decomposition:
- Package cachemem_pkg:
  - Default DATA_W, TAG_W and IDX_W localparams.
  - Function clog2_min1 for AGE_W.
  - A way-select-result typedef {hit, way, victim_way, victim_dirty}.
- One sub-module, cache_lru_update: combinational. Takes a set's age vector plus a touch way and enable, and returns the new age vector. Instantiated twice in series (read touch, then write touch) on the write/read set path.

Test Plan:
- Reset, then read idx 5 tag 0x3 -> rd1_valid=0, rd1_data=0, evict_valid stays 0.
- WAYS=2:
  - Steps: write idx 5 tag 0xA data 0x11 (dirty=1), then write tag 0xB data 0x22 (dirty=0), then read tag 0xA with rd1_en, then write tag 0xC data 0x33.
  - Required: tag 0xB (LRU, clean) replaced, no evict pulse; read 0xA -> 0x11, read 0xC -> 0x33.
- Continue: write tag 0xD idx 5 -> victim is 0xA (LRU, dirty). Next cycle evict_valid=1, evict_idx=5, evict_tag=0xA, evict_data=0x11; the cycle after, evict_valid=0.
- Write hit: write tag 0xC dirty=1 data 0x44 -> in-place update, no evict. Then force-evict 0xC -> evict_data=0x44.
- Invalidate idx 5 tag 0xD together with write idx 5 tag 0xE -> 0xD gone; 0xE hits; no evict for 0xD even if dirty.
- WAYS=4, same set:
  - Steps: fill 4 tags, touch them in order 2,0,3,1, then write a 5th tag.
  - Required: way 2 replaced. Reset asserted mid-sequence -> all reads miss and evict_valid=0 the next cycle.
